// File: rtl/risc16_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc16_ctrl_pkg
// Description : Shared opcode, state, ALU-op and source-mux encodings for the
//               RISC16 multi-cycle control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package risc16_ctrl_pkg;

  // Sequencer states; the numeric values are visible on the debug port
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_LATCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  // Opcodes held in instruction bits [15:12]
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h4;
  localparam logic [3:0] OP_ST  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_BEQ = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operation codes
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // Writeback source select: S is the ALU result, DS is memory/immediate
  localparam logic SMUX_S  = 1'b0;
  localparam logic SMUX_DS = 1'b1;

  // ALU operation required by an opcode during EXEC
  function automatic logic [2:0] alu_for(input logic [3:0] op);
    logic [2:0] r;
    r = ALU_PASS;
    if (op == OP_ADD) r = ALU_ADD;
    if (op == OP_SUB) r = ALU_SUB;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/smux_seq_ctrl_ack_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ack_timeout_cnt
// Description : Saturating wait counter for a memory handshake. The expired
//               flag rises on the wait cycle whose increment brings the count
//               to ACK_TIMEOUT, so the caller can trap on that same edge
//               unless an acknowledge arrives in that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ack_timeout_cnt #(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise count up and stick at the limit
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != C_LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q >= C_LAST);

endmodule
`default_nettype wire

// File: rtl/smux_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : smux_seq_ctrl
// Description : Multi-cycle control sequencer for the RISC16 datapath. Fetches
//               over a req/ack handshake, steps through decode, execute,
//               memory and writeback, and drives the S/DS source mux, ALU op,
//               register write, PC strobes and sticky halt/error status.
//               Every output is a flop loaded from the decode of the next
//               state, so outputs are Moore in the state and latched opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module smux_seq_ctrl
  import risc16_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_data,
  input  logic        mem_ack,
  input  logic        zero_flag,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic [2:0]  alu_op,
  output logic        smux_sel,
  output logic        rf_we,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state_o
);

  state_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic        br_q, br_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        ir_ld_q, ir_ld_d;
  logic        pc_inc_q, pc_inc_d;
  logic        pc_ld_q, pc_ld_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        smux_sel_q, smux_sel_d;
  logic        rf_we_q, rf_we_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;

  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_expired;

  // Only the opcode field of the instruction word matters to control
  logic        unused_mem_low;
  assign unused_mem_low = ^mem_data[11:0];

  // One wait counter shared by the fetch and data-memory handshakes
  ack_timeout_cnt #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_ack_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  // Next-state, opcode capture, branch sampling and counter control
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    br_d     = br_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          opcode_d = mem_data[15:12];
          state_d  = ST_LATCH;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) state_d = ST_TRAP;
        end
      end
      ST_LATCH: begin
        cnt_clr = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // zero_flag is captured here so the branch strobe can stay Moore
        br_d = zero_flag;
        case (opcode_q)
          OP_NOP:                               state_d = ST_FETCH;
          OP_ADD, OP_SUB, OP_LDI, OP_JMP, OP_BEQ: state_d = ST_EXEC;
          OP_LD, OP_ST:                         state_d = ST_MEM;
          OP_HLT:                               state_d = ST_HALT;
          default:                              state_d = ST_TRAP;
        endcase
      end
      ST_EXEC: begin
        if (opcode_q == OP_ADD || opcode_q == OP_SUB || opcode_q == OP_LDI) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          cnt_clr = 1'b1;
          state_d = (opcode_q == OP_LD) ? ST_WB : ST_FETCH;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) state_d = ST_TRAP;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  // Output decode of the state about to be entered
  always_comb begin
    mem_req_d  = (state_d == ST_FETCH) || (state_d == ST_MEM);
    mem_we_d   = (state_d == ST_MEM) && (opcode_d == OP_ST);
    ir_ld_d    = (state_d == ST_LATCH);
    pc_inc_d   = (state_d == ST_LATCH);
    pc_ld_d    = (state_d == ST_EXEC) &&
                 ((opcode_d == OP_JMP) || ((opcode_d == OP_BEQ) && br_d));
    alu_op_d   = (state_d == ST_EXEC) ? alu_for(opcode_d) : ALU_PASS;
    smux_sel_d = SMUX_S;
    if ((state_d == ST_WB) && ((opcode_d == OP_LD) || (opcode_d == OP_LDI))) begin
      smux_sel_d = SMUX_DS;
    end
    rf_we_d    = (state_d == ST_WB);
    halted_d   = (state_d == ST_HALT);
    err_d      = (state_d == ST_TRAP);
  end

  // State, opcode, branch flag and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      opcode_q   <= OP_NOP;
      br_q       <= 1'b0;
      mem_req_q  <= 1'b1;
      mem_we_q   <= 1'b0;
      ir_ld_q    <= 1'b0;
      pc_inc_q   <= 1'b0;
      pc_ld_q    <= 1'b0;
      alu_op_q   <= ALU_PASS;
      smux_sel_q <= SMUX_S;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      br_q       <= br_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      ir_ld_q    <= ir_ld_d;
      pc_inc_q   <= pc_inc_d;
      pc_ld_q    <= pc_ld_d;
      alu_op_q   <= alu_op_d;
      smux_sel_q <= smux_sel_d;
      rf_we_q    <= rf_we_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign ir_ld    = ir_ld_q;
  assign pc_inc   = pc_inc_q;
  assign pc_ld    = pc_ld_q;
  assign alu_op   = alu_op_q;
  assign smux_sel = smux_sel_q;
  assign rf_we    = rf_we_q;
  assign halted   = halted_q;
  assign err      = err_q;
  assign state_o  = state_q;

endmodule
`default_nettype wire
